serial_key_matcher: RTL
=======================

# serial_key_matcher

Parametrised serial-to-parallel key matcher for the crypto datapath. It accepts a framed serial bit stream, assembles a WIDTH-bit word, and checks it against a table of NUM_KEYS constant keys, one key per cycle. It reports a hit or miss, the matching key index, and any length error. It is the generalised successor of the fixed 128-bit parse-and-compare front end, adding width, key-count and bit-order parameters, input qualification, length checking and a busy/result handshake.

## Interface
- WIDTH, 128: word length in bits, ≥ 2.
- NUM_KEYS, 4: number of stored keys, ≥ 1.
- KEYS, defaults from the shared include: flat WIDTH*NUM_KEYS vector; key i is KEYS[i*WIDTH +: WIDTH].
- MSB_FIRST, 1: 1 means the first received bit becomes word[WIDTH-1]; 0 means the first bit becomes word[0].

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  qualifies in_data and end_of_sequence.
- in_data  in  1  serial bit.
- end_of_sequence  in  1  marks the last bit of a frame; valid only with in_valid.
- busy  out  1  high in CMP and DONE; input ignored while high.
- match_valid  out  1  one-cycle result strobe.
- match  out  1  hit flag; meaningful only with match_valid.
- match_idx  out  clog2(NUM_KEYS) (min 1)  index of the hit key; 0 on a miss.
- len_err  out  1  frame length ≠ WIDTH; meaningful only with match_valid.
- word  out  WIDTH  assembled word; held stable from entering CMP until the next frame's first bit.

## Operation
- States: RECV, CMP, DONE. Reset values: RECV, bit count 0, idx 0, word 0, and every output 0.
- RECV:
  - Each cycle with in_valid, shift in_data into the word in MSB_FIRST order.
  - The bit counter (clog2(WIDTH+1) bits) increments and saturates at WIDTH.
  - A bit received while the count is already WIDTH sets a sticky overrun flag; the word is not modified.
- end_of_sequence && in_valid in RECV:
  - The bit in that cycle is part of the frame.
  - If the total count including that bit is exactly WIDTH and no overrun occurred: go to CMP with idx = 0.
  - Otherwise: go to DONE with match = 0, len_err = 1, match_idx = 0.
- CMP:
  - Compare word with key idx.
  - On equality: go to DONE with match = 1, match_idx = idx.
  - On mismatch with idx = NUM_KEYS-1: go to DONE with match = 0.
  - Otherwise: idx++.
  - Lowest index wins when keys are duplicated.
- DONE:
  - match_valid = 1 for exactly one cycle.
  - Clear count, overrun and idx, then return to RECV. match, match_idx and len_err hold until the next result.
- end_of_sequence without in_valid is ignored.
- in_valid during CMP or DONE is dropped and does not count toward the next frame.
- Reset mid-frame or mid-compare aborts immediately; no match_valid is emitted for the aborted frame.

## Timing
- Let E be the cycle in which end_of_sequence is sampled.
- A hit on key k gives match_valid high in cycle E+2+k.
- A miss gives match_valid in E+1+NUM_KEYS.
- A length error gives match_valid in E+1.
- busy rises in E+1 and falls with the match_valid cycle. The earliest first bit of the next frame is the cycle after match_valid.
- Back-to-back frames are therefore separated by at least 2+k cycles of idle input. The source must honour busy.
- No combinational path from inputs to outputs.

## Structure
- Shared include `crypto_defs.vh`:
  - state encodings RECV/CMP/DONE;
  - default test key constants;
  - a clog2 function.
- One natural sub-module: `bit_deserializer`, containing the shift register, bit counter, overrun flag and MSB_FIRST ordering, with inputs clear and enable. The FSM and key mux stay in the top module.

## Test plan
All scenarios use WIDTH=16, NUM_KEYS=4, KEYS = key0 16'h1234, key1 16'hCAFE, key2 16'hBEEF, key3 16'hDEAD, and MSB_FIRST=1 unless stated.
- Send 16'hBEEF MSB first with end_of_sequence on bit 16 → match_valid at E+4, match=1, match_idx=2, len_err=0, word=16'hBEEF.
- Send 16'h0000 → match_valid at E+5, match=0, match_idx=0, len_err=0.
- Send 15 bits, then 17 bits → each frame gives match_valid at E+1 with len_err=1 and match=0.
- Deassert in_valid for 3 cycles between bits of 16'h1234 and toggle in_data while it is low → match at E+2, match_idx=0. Then send bits while busy → they are dropped, and the next 16'hDEAD frame still matches idx 3.
- With MSB_FIRST=0, send bits LSB first of 16'hCAFE → match_idx=1. Also drive rst_n low for one cycle during CMP → no match_valid, and all outputs read 0.

Source files
------------

// File: rtl/serial_key_matcher_pkg.sv
// serial_key_matcher_pkg: shared FSM states, default key table and width helpers
package serial_key_matcher_pkg;

    typedef enum logic [1:0] {RECV, CMP, DONE} state_t;

    // key i sits at bits [i*128 +: 128]
    localparam logic [4*128-1:0] DEFAULT_KEYS = {
        128'h8e73b0f7da0e6452c810f32b809079e5,
        128'h603deb1015ca71be2b73aef0857d7781,
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'h000102030405060708090a0b0c0d0e0f
    };

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int idx_width(input int n);
        return clog2(n) < 1 ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/serial_key_matcher_if.sv
// serial_key_matcher_if: serial frame input and match result bundle
interface serial_key_matcher_if import serial_key_matcher_pkg::*; #(
    parameter int WIDTH    = 128,
    parameter int NUM_KEYS = 4
);
    localparam int IDX_W = idx_width(NUM_KEYS);

    logic             in_valid;
    logic             in_data;
    logic             end_of_sequence;
    logic             busy;
    logic             match_valid;
    logic             match;
    logic [IDX_W-1:0] match_idx;
    logic             len_err;
    logic [WIDTH-1:0] word;

    modport master (
        output in_valid, in_data, end_of_sequence,
        input  busy, match_valid, match, match_idx, len_err, word
    );

    modport slave (
        input  in_valid, in_data, end_of_sequence,
        output busy, match_valid, match, match_idx, len_err, word
    );
endinterface

// File: rtl/serial_key_matcher_bit_deserializer.sv
// serial_key_matcher_bit_deserializer: shift register with saturating bit count and sticky overrun
module serial_key_matcher_bit_deserializer import serial_key_matcher_pkg::*; #(
    parameter int WIDTH     = 128,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CNT_W    = clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             data,
    output logic [WIDTH-1:0] word,
    output logic [CNT_W-1:0] count,
    output logic             overrun
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);

    // clear leaves word alone so the compared word stays visible until the next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word    <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else if (clear) begin
            count   <= '0;
            overrun <= 1'b0;
        end else if (enable) begin
            if (count == FULL) begin
                overrun <= 1'b1;
            end else begin
                word  <= MSB_FIRST ? {word[WIDTH-2:0], data} : {data, word[WIDTH-1:1]};
                count <= count + 1'b1;
            end
        end
    end
endmodule

// File: rtl/serial_key_matcher.sv
// serial_key_matcher: deserialises a framed bit stream and searches a constant key table
module serial_key_matcher import serial_key_matcher_pkg::*; #(
    parameter int                        WIDTH     = 128,
    parameter int                        NUM_KEYS  = 4,
    parameter logic [WIDTH*NUM_KEYS-1:0] KEYS      = DEFAULT_KEYS,
    parameter bit                        MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_key_matcher_if.slave  bus
);
    localparam int IDX_W = idx_width(NUM_KEYS);
    localparam int CNT_W = clog2(WIDTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] count;
    logic             overrun;
    logic [WIDTH-1:0] word;
    logic             busy;
    logic             match_valid;
    logic             match;
    logic [IDX_W-1:0] match_idx;
    logic             len_err;
    logic             hit;

    assign hit = word == KEYS[idx*WIDTH +: WIDTH];

    serial_key_matcher_bit_deserializer #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) deser (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state == DONE),
        .enable  (bus.in_valid && state == RECV),
        .data    (bus.in_data),
        .word    (word),
        .count   (count),
        .overrun (overrun)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RECV;
            idx         <= '0;
            busy        <= 1'b0;
            match_valid <= 1'b0;
            match       <= 1'b0;
            match_idx   <= '0;
            len_err     <= 1'b0;
        end else begin
            case (state)
                RECV: if (bus.in_valid && bus.end_of_sequence) begin
                    busy <= 1'b1;
                    // the final bit is still being shifted in, so a full frame shows WIDTH-1 here
                    if (count == LAST_BIT && !overrun) begin
                        state <= CMP;
                        idx   <= '0;
                    end else begin
                        state       <= DONE;
                        match_valid <= 1'b1;
                        match       <= 1'b0;
                        match_idx   <= '0;
                        len_err     <= 1'b1;
                    end
                end
                CMP: if (hit || idx == LAST_IDX) begin
                    state       <= DONE;
                    match_valid <= 1'b1;
                    match       <= hit;
                    match_idx   <= hit ? idx : '0;
                    len_err     <= 1'b0;
                end else begin
                    idx <= idx + 1'b1;
                end
                DONE: begin
                    state       <= RECV;
                    match_valid <= 1'b0;
                    busy        <= 1'b0;
                    idx         <= '0;
                end
                default: state <= RECV;
            endcase
        end
    end

    assign bus.busy        = busy;
    assign bus.match_valid = match_valid;
    assign bus.match       = match;
    assign bus.match_idx   = match_idx;
    assign bus.len_err     = len_err;
    assign bus.word        = word;
endmodule
